// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that lets NREQ requesters share the write port of one
// downstream synchronous FIFO. One requester is granted at a time. A grant
// lasts for at most MAX_BURST accepted beats. It ends earlier if the
// requester drops its valid. The FIFO full flag stalls the burst without
// ending it.
//
// Parameters
//   WIDTH      data width of each requester and of the FIFO write port
//   NREQ       number of requesters (2..8)
//   MAX_BURST  maximum beats per grant (1..16)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset, released synchronously
//   req_valid    per-requester write request
//   req_data     requester i data at [i*WIDTH +: WIDTH]
//   req_ready    per-requester accept (beat = valid & ready at clk rise)
//   fifo_full    full flag from the FIFO
//   fifo_wr_en   FIFO write enable
//   fifo_wdata   FIFO write data (zero when no write)
//   grant_id     index of the currently granted requester
//   busy         high while a grant is active
//   write_count  accepted beats since reset, wraps at 16 bits
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [WIDTH-1:0]          fifo_wdata,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic [15:0]               write_count
);

  localparam int GW = $clog2(NREQ);
  // One extra bit so the counter can hold MAX_BURST itself when the last
  // beat is taken; this also keeps the width non-zero when MAX_BURST is 1.
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   grant_nxt;
  logic [GW-1:0]   last_q;
  logic [GW-1:0]   last_nxt;
  logic [BW-1:0]   beat_q;
  logic [BW-1:0]   beat_nxt;
  logic [15:0]     wcnt_q;
  logic [15:0]     wcnt_nxt;

  logic [WIDTH-1:0] data_arr [NREQ];
  logic             sel_valid;

  // Round-robin search. The search starts one past the last requester that
  // released the port and wraps around. The releasing requester is
  // therefore checked last.
  function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                            input logic [GW-1:0]   last);
    logic [GW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && v[GW'(idx)]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
  end

  // Only the granted requester's valid matters. Activity on other
  // requesters cannot reach the outputs while a grant is held.
  assign sel_valid   = req_valid[grant_q];
  assign grant_id    = grant_q;
  assign write_count = wcnt_q;

  // Next-state and output decode
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_q;
    last_nxt   = last_q;
    beat_nxt   = beat_q;
    wcnt_nxt   = wcnt_q;
    busy       = 1'b0;
    fifo_wr_en = 1'b0;
    fifo_wdata = '0;
    req_ready  = '0;

    case (state)
      IDLE: begin
        // Arbitration only; no beat can transfer in this state.
        if (|req_valid) begin
          grant_nxt = rr_pick(req_valid, last_q);
          beat_nxt  = '0;
          state_nxt = GRANT;
        end
      end

      GRANT: begin
        busy = 1'b1;
        // fifo_full masks the write here, so the FIFO never sees a write
        // while it is full.
        fifo_wr_en         = sel_valid & ~fifo_full;
        req_ready[grant_q] = fifo_wr_en;
        if (fifo_wr_en) begin
          fifo_wdata = data_arr[grant_q];
          beat_nxt   = beat_q + BW'(1);
          wcnt_nxt   = wcnt_q + 16'd1;
          if (beat_q == LAST_BEAT) begin
            state_nxt = IDLE;
            last_nxt  = grant_q;
          end
        end else if (!sel_valid) begin
          // The requester withdrew. Release the port without a beat.
          state_nxt = IDLE;
          last_nxt  = grant_q;
        end
        // Otherwise the FIFO is full. Hold the grant and do not count a beat.
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      grant_q <= '0;
      // Requester 0 gets first priority after reset.
      last_q  <= GW'(NREQ - 1);
      beat_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      last_q  <= last_nxt;
      beat_q  <= beat_nxt;
      wcnt_q  <= wcnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Bench for fifo_wr_arbiter. The main instance uses the default parameters.
// A second instance with MAX_BURST=16 shares the inputs. It is used for the
// 16-bit write counter wrap, because its longer bursts reach 65536 beats in
// fewer cycles.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int WIDTH     = 8;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;
  localparam int GW        = 2;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  fifo_full;

  logic [NREQ-1:0]       req_ready;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_wdata;
  logic [GW-1:0]         grant_id;
  logic                  busy;
  logic [15:0]           write_count;

  logic [NREQ-1:0]       w_req_ready;
  logic                  w_fifo_wr_en;
  logic [WIDTH-1:0]      w_fifo_wdata;
  logic [GW-1:0]         w_grant_id;
  logic                  w_busy;
  logic [15:0]           w_write_count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state (transaction level)
  logic                  m_grant;
  logic [GW-1:0]         m_gid;
  logic [GW-1:0]         m_last;
  int                    m_beats;
  logic [15:0]           m_count;

  logic                  e_busy;
  logic                  e_wr_en;
  logic [NREQ-1:0]       e_ready;
  logic [WIDTH-1:0]      e_wdata;
  logic [GW-1:0]         e_gid;
  logic [15:0]           e_count;

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wdata(fifo_wdata), .grant_id(grant_id), .busy(busy),
    .write_count(write_count)
  );

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_BURST(16)) u_dut16 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(w_req_ready), .fifo_full(fifo_full), .fifo_wr_en(w_fifo_wr_en),
    .fifo_wdata(w_fifo_wdata), .grant_id(w_grant_id), .busy(w_busy),
    .write_count(w_write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [GW-1:0] model_pick(input logic [NREQ-1:0] v,
                                               input logic [GW-1:0]   last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[GW'((int'(last) + k) % NREQ)]) return GW'((int'(last) + k) % NREQ);
    end
    return '0;
  endfunction

  task automatic model_reset();
    m_grant = 1'b0;
    m_gid   = '0;
    m_last  = GW'(NREQ - 1);
    m_beats = 0;
    m_count = '0;
  endtask

  task automatic model_predict();
    e_busy  = m_grant;
    e_wr_en = m_grant && req_valid[m_gid] && !fifo_full;
    e_ready = e_wr_en ? (NREQ'(1) << m_gid) : '0;
    e_wdata = e_wr_en ? req_data[int'(m_gid)*WIDTH +: WIDTH] : '0;
    e_gid   = m_gid;
    e_count = m_count;
  endtask

  task automatic model_clock();
    if (!m_grant) begin
      if (|req_valid) begin
        m_gid   = model_pick(req_valid, m_last);
        m_beats = 0;
        m_grant = 1'b1;
      end
    end else if (req_valid[m_gid] && !fifo_full) begin
      m_beats++;
      m_count++;
      if (m_beats == MAX_BURST) begin
        m_grant = 1'b0;
        m_last  = m_gid;
      end
    end else if (!req_valid[m_gid]) begin
      m_grant = 1'b0;
      m_last  = m_gid;
    end
  endtask

  // Advance one clock. The model sees the same inputs as the DUT at the edge.
  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else model_clock();
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = '1;
    fifo_full = 1'b0;
    req_data  = $urandom;
    @(posedge clk);
    #3;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got=%b exp=0", fifo_wr_en); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    n_vec++; if (fifo_wdata !== 8'h00) begin n_err++; $display("FAIL reset_wdata got=%h exp=00", fifo_wdata); end
    n_vec++; if (write_count !== 16'h0000) begin n_err++; $display("FAIL reset_wcount got=%h exp=0000", write_count); end
    n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
    reset = 1'b1;
    model_reset();
    #1;
    n_vec++; if (fifo_wr_en !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL idle_no_beat wr_en=%b busy=%b exp=0,0", fifo_wr_en, busy); end
    tick();
    #2;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL arb_latency busy got=%b exp=1", busy); end
    n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL first_grant got=%0d exp=0", grant_id); end
  endtask

  task automatic test_round_robin();
    int gq[$];
    int bq[$];
    int cur;
    int idle;
    logic prev_busy;
    do_reset();
    req_valid = '1;
    cur = 0; idle = 0; prev_busy = 1'b0;
    for (int cyc = 0; cyc < 60 && gq.size() < 5; cyc++) begin
      req_data = $urandom;
      #2;
      model_predict();
      n_vec++; if (fifo_wr_en !== e_wr_en) begin n_err++; $display("FAIL rr_wr_en cyc=%0d got=%b exp=%b", cyc, fifo_wr_en, e_wr_en); end
      n_vec++; if (req_ready !== e_ready) begin n_err++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
      if (!busy) idle++;
      if (busy && !prev_busy) begin
        if (gq.size() > 0) begin
          n_vec++; if (idle != 1) begin n_err++; $display("FAIL rr_idle_gap got=%0d exp=1", idle); end
        end
        idle = 0;
        cur  = 0;
        gq.push_back(int'(grant_id));
        if (gq.size() == 5) begin
          n_vec++; if (write_count !== 16'd16) begin n_err++; $display("FAIL rr_wcount got=%0d exp=16", write_count); end
        end
      end
      if (fifo_wr_en) cur++;
      if (!busy && prev_busy) bq.push_back(cur);
      prev_busy = busy;
      tick();
    end
    n_vec++;
    if (gq.size() < 5 || bq.size() < 4) begin
      n_err++; $display("FAIL rr_timeout grants=%0d bursts=%0d exp=5,4", gq.size(), bq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_vec++; if (gq[i] != i % 4) begin n_err++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, gq[i], i % 4); end
      end
      for (int i = 0; i < 4; i++) begin
        n_vec++; if (bq[i] != 4) begin n_err++; $display("FAIL rr_burst_len idx=%0d got=%0d exp=4", i, bq[i]); end
      end
    end
  endtask

  task automatic test_single_req();
    logic [WIDTH-1:0] items [10];
    logic [WIDTH-1:0] got[$];
    int bq[$];
    int sent;
    int cur;
    logic prev_busy;
    logic acc;
    do_reset();
    for (int i = 0; i < 10; i++) items[i] = WIDTH'($urandom);
    sent = 0; cur = 0; prev_busy = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      req_valid = (sent < 10) ? 4'b0100 : 4'b0000;
      req_data  = $urandom;
      if (sent < 10) req_data[2*WIDTH +: WIDTH] = items[sent];
      #2;
      model_predict();
      n_vec++; if (fifo_wr_en !== e_wr_en) begin n_err++; $display("FAIL single_wr_en cyc=%0d got=%b exp=%b", cyc, fifo_wr_en, e_wr_en); end
      n_vec++; if (fifo_wdata !== e_wdata) begin n_err++; $display("FAIL single_wdata cyc=%0d got=%h exp=%h", cyc, fifo_wdata, e_wdata); end
      if (busy) begin
        n_vec++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL single_gid cyc=%0d got=%0d exp=2", cyc, grant_id); end
      end
      if (busy && !prev_busy) cur = 0;
      if (fifo_wr_en) begin got.push_back(fifo_wdata); cur++; end
      if (!busy && prev_busy) bq.push_back(cur);
      acc = req_valid[2] && req_ready[2];
      prev_busy = busy;
      tick();
      if (acc) sent++;
    end
    n_vec++;
    if (got.size() != 10) begin
      n_err++; $display("FAIL single_count got=%0d exp=10", got.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_vec++; if (got[i] !== items[i]) begin n_err++; $display("FAIL single_order idx=%0d got=%h exp=%h", i, got[i], items[i]); end
      end
    end
    n_vec++;
    if (bq.size() != 3) begin
      n_err++; $display("FAIL single_bursts got=%0d exp=3", bq.size());
    end else if (bq[0] != 4 || bq[1] != 4 || bq[2] != 2) begin
      n_err++; $display("FAIL single_burst_len got=%0d,%0d,%0d exp=4,4,2", bq[0], bq[1], bq[2]);
    end
  endtask

  task automatic test_fifo_stall();
    int beats;
    int stall;
    logic seen;
    logic ended;
    logic acc;
    do_reset();
    req_valid = 4'b0010;
    beats = 0; stall = 5; seen = 1'b0; ended = 1'b0;
    for (int cyc = 0; cyc < 30 && !ended; cyc++) begin
      fifo_full = (beats == 2 && stall > 0);
      req_data  = $urandom;
      #2;
      model_predict();
      n_vec++; if (fifo_wr_en !== e_wr_en) begin n_err++; $display("FAIL stall_wr_en cyc=%0d got=%b exp=%b", cyc, fifo_wr_en, e_wr_en); end
      n_vec++; if (fifo_wdata !== e_wdata) begin n_err++; $display("FAIL stall_wdata cyc=%0d got=%h exp=%h", cyc, fifo_wdata, e_wdata); end
      if (fifo_full) begin
        n_vec++;
        if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
          n_err++; $display("FAIL stall_hold cyc=%0d wr_en=%b ready=%b busy=%b exp=0,0000,1", cyc, fifo_wr_en, req_ready, busy);
        end
        stall--;
      end
      if (busy) begin
        seen = 1'b1;
        n_vec++; if (grant_id !== 2'd1) begin n_err++; $display("FAIL stall_gid got=%0d exp=1", grant_id); end
      end
      if (!busy && seen) ended = 1'b1;
      acc = fifo_wr_en;
      tick();
      if (acc) beats++;
    end
    fifo_full = 1'b0;
    n_vec++; if (!ended || beats != 4 || stall != 0) begin n_err++; $display("FAIL stall_burst beats=%0d stall_left=%0d ended=%b exp=4,0,1", beats, stall, ended); end
  endtask

  task automatic test_withdraw();
    do_reset();
    req_valid = 4'b1000;
    req_data  = $urandom;
    #2;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wd_idle got=%b exp=0", busy); end
    tick();
    req_valid = 4'b1001;
    #2;
    n_vec++; if (busy !== 1'b1 || grant_id !== 2'd3) begin n_err++; $display("FAIL wd_grant3 busy=%b gid=%0d exp=1,3", busy, grant_id); end
    n_vec++; if (fifo_wr_en !== 1'b1 || req_ready !== 4'b1000) begin n_err++; $display("FAIL wd_beat wr_en=%b ready=%b exp=1,1000", fifo_wr_en, req_ready); end
    n_vec++; if (fifo_wdata !== req_data[3*WIDTH +: WIDTH]) begin n_err++; $display("FAIL wd_wdata got=%h exp=%h", fifo_wdata, req_data[3*WIDTH +: WIDTH]); end
    tick();
    req_valid = 4'b0001;
    #2;
    n_vec++; if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin n_err++; $display("FAIL wd_drop wr_en=%b ready=%b busy=%b exp=0,0000,1", fifo_wr_en, req_ready, busy); end
    tick();
    #2;
    n_vec++; if (busy !== 1'b0 || write_count !== 16'd1) begin n_err++; $display("FAIL wd_release busy=%b wcount=%0d exp=0,1", busy, write_count); end
    tick();
    #2;
    n_vec++; if (busy !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001) begin n_err++; $display("FAIL wd_regrant busy=%b gid=%0d ready=%b exp=1,0,0001", busy, grant_id, req_ready); end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid = 4'b1111;
    req_data  = $urandom;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL areset_ctrl busy=%b wr_en=%b exp=0,0", busy, fifo_wr_en); end
    n_vec++; if (req_ready !== 4'b0000 || fifo_wdata !== 8'h00) begin n_err++; $display("FAIL areset_data ready=%b wdata=%h exp=0000,00", req_ready, fifo_wdata); end
    n_vec++; if (write_count !== 16'h0000) begin n_err++; $display("FAIL areset_wcount got=%0d exp=0", write_count); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    tick();
    #2;
    n_vec++; if (busy !== 1'b1 || grant_id !== 2'd0) begin n_err++; $display("FAIL areset_prio busy=%b gid=%0d exp=1,0", busy, grant_id); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      if ($urandom_range(0, 1) == 0) req_valid = NREQ'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      req_data  = $urandom;
      #2;
      model_predict();
      n_vec++; if (busy !== e_busy) begin n_err++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
      n_vec++; if (fifo_wr_en !== e_wr_en) begin n_err++; $display("FAIL rand_wr_en cyc=%0d got=%b exp=%b", cyc, fifo_wr_en, e_wr_en); end
      n_vec++; if (req_ready !== e_ready) begin n_err++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
      n_vec++; if (fifo_wdata !== e_wdata) begin n_err++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", cyc, fifo_wdata, e_wdata); end
      n_vec++; if (grant_id !== e_gid) begin n_err++; $display("FAIL rand_gid cyc=%0d got=%0d exp=%0d", cyc, grant_id, e_gid); end
      n_vec++; if (write_count !== e_count) begin n_err++; $display("FAIL rand_wcount cyc=%0d got=%0d exp=%0d", cyc, write_count, e_count); end
      tick();
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_wcount_wrap();
    int   beats;
    logic done;
    logic acc;
    do_reset();
    req_valid = '1;
    beats = 0;
    done  = 1'b0;
    for (int cyc = 0; cyc < 80000 && !done; cyc++) begin
      req_data = $urandom;
      #2;
      acc = w_fifo_wr_en;
      tick();
      if (acc) begin
        beats++;
        if (beats == 65535) begin
          n_vec++; if (w_write_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preset got=%h exp=ffff", w_write_count); end
        end
        if (beats == 65536) begin
          n_vec++; if (w_write_count !== 16'h0000) begin n_err++; $display("FAIL wrap_rollover got=%h exp=0000", w_write_count); end
          done = 1'b1;
        end
      end
    end
    n_vec++; if (!done) begin n_err++; $display("FAIL wrap_timeout beats=%0d exp=65536", beats); end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    model_reset();
    test_reset();
    test_round_robin();
    test_single_req();
    test_fifo_stall();
    test_withdraw();
    test_async_reset();
    test_random();
    test_wcount_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
